block_sum_accumulator: RTL

//  Integrate-and-dump stage directly downstream of the registered pair adder.

---
 rtl/block_sum_accumulator_pkg.sv | 14 +
 rtl/block_sum_accumulator_block_counter.sv | 39 +++
 rtl/block_sum_accumulator.sv | 118 +++++++++++
 3 files changed

// File: rtl/block_sum_accumulator_pkg.sv
// Shared defaults and output-slot state encoding for the block sum accumulator.
// The package replaces a radar_defs.vh include so that every file imports the same values.
package block_sum_accumulator_pkg;

  localparam int WL_DEF   = 4;
  localparam int N_DEF    = 16;
  localparam int LOGN_DEF = 4;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/block_sum_accumulator_block_counter.sv
// Modulo-N sample counter with enable and synchronous clear.
// tc is high whenever the count is at N-1, i.e. the next enabled sample closes the block.
module block_counter
  import block_sum_accumulator_pkg::*;
#(
  parameter int LOGN = LOGN_DEF,
  parameter int N    = N_DEF
) (
  input  logic            iCLK,
  input  logic            iRSTn,
  input  logic            en,
  input  logic            clr,
  output logic [LOGN-1:0] cnt,
  output logic            tc
);

  logic [LOGN-1:0] cnt_r;

  // sample count register; clear wins over enable
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      cnt_r <= {LOGN{1'b0}};
    end else if (clr) begin
      cnt_r <= {LOGN{1'b0}};
    end else if (en) begin
      if (cnt_r == LOGN'(N - 1)) begin
        cnt_r <= {LOGN{1'b0}};
      end else begin
        cnt_r <= cnt_r + LOGN'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;
  assign tc  = (cnt_r == LOGN'(N - 1));

endmodule

// File: rtl/block_sum_accumulator.sv
// Integrate-and-dump: sums N input samples and holds each block total in a
// single-entry valid/ready output slot; totals arriving while the slot is blocked are dropped.
module block_sum_accumulator
  import block_sum_accumulator_pkg::*;
#(
  parameter int WL   = WL_DEF,
  parameter int N    = N_DEF,
  parameter int LOGN = LOGN_DEF
) (
  input  logic                iCLK,
  input  logic                iRSTn,
  input  logic                iEN,
  input  logic [WL:0]         idata,
  input  logic                iCLR,
  input  logic                iREADY,
  output logic [WL+LOGN:0]    odata,
  output logic                oVALID,
  output logic [LOGN-1:0]     oCNT,
  output logic                oDROP
);

  localparam int AW = WL + 1 + LOGN;

  logic [AW-1:0]   acc_r;
  logic [AW-1:0]   odata_r;
  logic [AW-1:0]   total_s;
  logic            drop_r;
  logic            sample_s;
  logic            done_s;
  logic            tc_s;
  logic            load_s;
  logic            lose_s;
  logic [LOGN-1:0] cnt_s;
  slot_state_e     state_r;
  slot_state_e     state_s;

  assign sample_s = iEN & ~iCLR;
  assign done_s   = sample_s & tc_s;
  assign total_s  = acc_r + {{LOGN{1'b0}}, idata};

  block_counter #(
    .LOGN (LOGN),
    .N    (N)
  ) u_block_counter (
    .iCLK  (iCLK),
    .iRSTn (iRSTn),
    .en    (sample_s),
    .clr   (iCLR),
    .cnt   (cnt_s),
    .tc    (tc_s)
  );

  // running block sum, emptied on abort and after the closing sample
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      acc_r <= {AW{1'b0}};
    end else if (iCLR || done_s) begin
      acc_r <= {AW{1'b0}};
    end else if (sample_s) begin
      acc_r <= total_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  // output slot next state: a completion refills the slot only if it is free or being drained
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    lose_s  = 1'b0;
    case (state_r)
      SLOT_EMPTY: begin
        if (done_s) begin
          load_s  = 1'b1;
          state_s = SLOT_FULL;
        end else begin
          state_s = SLOT_EMPTY;
        end
      end
      SLOT_FULL: begin
        if (done_s) begin
          if (iREADY) begin
            load_s = 1'b1;
          end else begin
            lose_s = 1'b1;
          end
          state_s = SLOT_FULL;
        end else if (iREADY) begin
          state_s = SLOT_EMPTY;
        end else begin
          state_s = SLOT_FULL;
        end
      end
      default: begin
        state_s = SLOT_EMPTY;
      end
    endcase
  end

  // slot state, held total and sticky drop flag
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_r <= SLOT_EMPTY;
      odata_r <= {AW{1'b0}};
      drop_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      odata_r <= load_s ? total_s : odata_r;
      drop_r  <= drop_r | lose_s;
    end
  end

  assign odata  = odata_r;
  assign oVALID = (state_r == SLOT_FULL);
  assign oCNT   = cnt_s;
  assign oDROP  = drop_r;

endmodule
